cdb_arbiter: RTL and testbench

Shares the N-wide completion broadcast (CDB) among all functional units. Each cycle it picks up to `N` completing FU results in round-robin order, grants those FUs, and registers the winning destination physical registers (T_new). Those registers feed the complete list's `inputs_completing` / `num_completing_valid` ports and the reservation-station wakeup logic one cycle later.

---
 rtl/sys_defs_pkg.sv | 13 +
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_rr_multi_select.sv | 46 ++++
 rtl/cdb_arbiter.sv | 81 ++++++++
 tb/tb_cdb_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sys_defs_pkg.sv
// Shared machine-wide sizing for the out-of-order core: CDB width,
// physical register tag type and the default functional-unit count.
package sys_defs;

    localparam int N                = 3;
    localparam int NUM_FU_DEFAULT   = 8;
    localparam int PHYS_REG_ID_BITS = 6;
    localparam int NUM_SCALAR_BITS  = $clog2(N + 1);
    localparam int SLOT_BITS        = (N > 1) ? $clog2(N) : 1;

    typedef logic [PHYS_REG_ID_BITS-1:0] PHYS_REG_IDX;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request/grant handshake plus the registered CDB broadcast.
// master = functional-unit side, slave = the arbiter.
interface cdb_arbiter_if
    import sys_defs::*;
#(
    parameter int NUM_FU   = NUM_FU_DEFAULT,
    parameter int PTR_BITS = $clog2(NUM_FU)
) ();

    logic                       squash;
    logic [NUM_FU-1:0]          fu_req_valid;
    PHYS_REG_IDX [NUM_FU-1:0]   fu_req_preg;
    logic [NUM_FU-1:0]          fu_req_ready;
    PHYS_REG_IDX [N-1:0]        cdb_preg;
    logic [NUM_SCALAR_BITS-1:0] num_cdb_valid;
    logic [PTR_BITS-1:0]        rr_ptr;

    modport master (
        output squash, fu_req_valid, fu_req_preg,
        input  fu_req_ready, cdb_preg, num_cdb_valid, rr_ptr
    );

    modport slave (
        input  squash, fu_req_valid, fu_req_preg,
        output fu_req_ready, cdb_preg, num_cdb_valid, rr_ptr
    );

endinterface

// File: rtl/cdb_arbiter_rr_multi_select.sv
// Combinational rotating-priority selector: picks up to N requesters
// starting at ptr_i, wrapping modulo NUM_FU, and reports slot order.
module rr_multi_select
    import sys_defs::*;
#(
    parameter int NUM_FU   = NUM_FU_DEFAULT,
    parameter int PTR_BITS = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]               req_i,
    input  logic [PTR_BITS-1:0]             ptr_i,
    output logic [NUM_FU-1:0]               grant_o,
    output logic [N-1:0][NUM_FU-1:0]        slot_sel_o,
    output logic [NUM_SCALAR_BITS-1:0]      count_o,
    output logic [PTR_BITS-1:0]             last_o
);

    logic [PTR_BITS:0]          pos;
    logic [PTR_BITS-1:0]        idx;
    logic [NUM_SCALAR_BITS-1:0] cnt;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant_o    = '0;
        slot_sel_o = '0;
        last_o     = '0;
        cnt        = '0;
        pos        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            // Explicit wrap so non-power-of-two FU counts rotate correctly.
            pos = {1'b0, ptr_i} + (PTR_BITS+1)'(k);
            if (pos >= (PTR_BITS+1)'(NUM_FU)) begin
                pos = pos - (PTR_BITS+1)'(NUM_FU);
            end
            idx = pos[PTR_BITS-1:0];
            if (req_i[idx] && (cnt < NUM_SCALAR_BITS'(N))) begin
                grant_o[idx]                       = 1'b1;
                slot_sel_o[cnt[SLOT_BITS-1:0]][idx] = 1'b1;
                last_o                             = idx;
                cnt                                = cnt + NUM_SCALAR_BITS'(1);
            end
        end
        count_o = cnt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to N completing FUs per cycle in round-robin
// order and registers their destination tags for next-cycle broadcast.
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int NUM_FU   = NUM_FU_DEFAULT,
    parameter int PTR_BITS = $clog2(NUM_FU)
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    logic [NUM_FU-1:0]          grant;
    logic [N-1:0][NUM_FU-1:0]   slot_sel;
    logic [NUM_SCALAR_BITS-1:0] grant_cnt;
    logic [PTR_BITS-1:0]        last_idx;
    PHYS_REG_IDX [N-1:0]        packed_preg;

    logic [PTR_BITS-1:0]        rr_ptr_q,   rr_ptr_d;
    PHYS_REG_IDX [N-1:0]        cdb_preg_q, cdb_preg_d;
    logic [NUM_SCALAR_BITS-1:0] num_q,      num_d;

    rr_multi_select #(
        .NUM_FU   (NUM_FU),
        .PTR_BITS (PTR_BITS)
    ) u_select (
        .req_i      (bus.fu_req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .slot_sel_o (slot_sel),
        .count_o    (grant_cnt),
        .last_o     (last_idx)
    );

    // Ready depends only on valid and the pointer, never on ready itself.
    assign bus.fu_req_ready = (reset && !bus.squash) ? grant : '0;

    always_comb begin
        packed_preg = '0;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (slot_sel[s][i]) begin
                    packed_preg[s] = packed_preg[s] | bus.fu_req_preg[i];
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cdb_preg_d = '0;
        num_d      = '0;
        if (!bus.squash) begin
            cdb_preg_d = packed_preg;
            num_d      = grant_cnt;
            if (grant_cnt != '0) begin
                rr_ptr_d = (last_idx == PTR_BITS'(NUM_FU - 1)) ? '0
                                                               : last_idx + PTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            cdb_preg_q <= '0;
            num_q      <= '0;
        end else begin
            // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
            rr_ptr_q   <= rr_ptr_d;
            cdb_preg_q <= cdb_preg_d;
            num_q      <= num_d;
        end
    end

    assign bus.rr_ptr        = rr_ptr_q;
    assign bus.cdb_preg      = cdb_preg_q;
    assign bus.num_cdb_valid = num_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then randomized traffic,
// all compared against a queue-based round-robin reference model.
module tb_cdb_arbiter;
    import sys_defs::*;

    localparam int NUM_FU   = 8;
    localparam int PTR_BITS = $clog2(NUM_FU);

    typedef PHYS_REG_IDX [NUM_FU-1:0] preg_vec_t;

    logic clock;
    logic reset;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .PTR_BITS(PTR_BITS)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .PTR_BITS(PTR_BITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic preg_vec_t seq_pregs();
        preg_vec_t p;
        for (int i = 0; i < NUM_FU; i++) p[i] = PHYS_REG_IDX'(i + 32);
        return p;
    endfunction

    function automatic logic [63:0] slots(input int a, input int b, input int c);
        return 64'({PHYS_REG_IDX'(c), PHYS_REG_IDX'(b), PHYS_REG_IDX'(a)});
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_cycle(input logic [NUM_FU-1:0] v, input preg_vec_t p,
                            input logic sq, output logic [NUM_FU-1:0] g);
        int          order[$];
        logic [NUM_FU-1:0] exp_ready;
        logic [63:0] exp_cdb;
        exp_ready = '0;
        exp_cdb   = '0;
        bus.fu_req_valid = v;
        bus.fu_req_preg  = p;
        bus.squash       = sq;
        #1;
        if (!sq) begin
            for (int k = 0; k < NUM_FU; k++) begin
                int i;
                i = (m_ptr + k) % NUM_FU;
                if (v[i] && order.size() < N) order.push_back(i);
            end
        end
        foreach (order[s]) begin
            exp_ready[order[s]] = 1'b1;
            exp_cdb = exp_cdb | (64'(p[order[s]]) << (s * PHYS_REG_ID_BITS));
        end
        check("ready", 64'(bus.fu_req_ready), 64'(exp_ready));
        @(posedge clock);
        #1;
        if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NUM_FU;
        check("num", 64'(bus.num_cdb_valid), 64'(order.size()));
        check("cdb", 64'(bus.cdb_preg), exp_cdb);
        check("ptr", 64'(bus.rr_ptr), 64'(m_ptr));
        g = exp_ready;
    endtask

    initial begin
        logic [NUM_FU-1:0] g;
        logic [NUM_FU-1:0] v;
        logic              sq;
        preg_vec_t         p;
        int                rot_ptr [4];
        rot_ptr = '{3, 6, 1, 4};

        // Reset held with every FU requesting.
        reset            = 1'b0;
        bus.squash       = 1'b0;
        bus.fu_req_valid = '1;
        bus.fu_req_preg  = seq_pregs();
        #1;
        check("rst_ready", 64'(bus.fu_req_ready), 64'(0));
        check("rst_num", 64'(bus.num_cdb_valid), 64'(0));
        check("rst_ptr", 64'(bus.rr_ptr), 64'(0));
        @(posedge clock);
        #1;
        check("rst_hold_ready", 64'(bus.fu_req_ready), 64'(0));
        check("rst_hold_num", 64'(bus.num_cdb_valid), 64'(0));
        reset = 1'b1;
        m_ptr = 0;

        // Over-subscribed rotation.
        for (int c = 0; c < 4; c++) begin
            do_cycle('1, seq_pregs(), 1'b0, g);
            check("rot_ptr", 64'(bus.rr_ptr), 64'(rot_ptr[c]));
            if (c == 0) check("rel_cdb", 64'(bus.cdb_preg), slots(32, 33, 34));
        end

        // Single request at FU 7 moves the pointer to 0.
        do_cycle(8'h80, seq_pregs(), 1'b0, g);
        check("to0_ptr", 64'(bus.rr_ptr), 64'(0));

        // Under-subscribed.
        p    = seq_pregs();
        p[1] = PHYS_REG_IDX'(12);
        p[5] = PHYS_REG_IDX'(40);
        do_cycle(8'b0010_0010, p, 1'b0, g);
        check("under_cdb", 64'(bus.cdb_preg), slots(12, 40, 0));
        check("under_num", 64'(bus.num_cdb_valid), 64'(2));
        check("under_ptr", 64'(bus.rr_ptr), 64'(6));

        // Idle hold.
        repeat (3) do_cycle('0, p, 1'b0, g);
        check("idle_ptr", 64'(bus.rr_ptr), 64'(6));
        check("idle_num", 64'(bus.num_cdb_valid), 64'(0));

        // Wrap-around from pointer 6.
        do_cycle(8'b1000_0101, seq_pregs(), 1'b0, g);
        check("wrap_cdb", 64'(bus.cdb_preg), slots(39, 32, 34));
        check("wrap_ptr", 64'(bus.rr_ptr), 64'(3));

        // Squash with three requesters.
        do_cycle(8'b0011_1000, seq_pregs(), 1'b1, g);
        check("squash_num", 64'(bus.num_cdb_valid), 64'(0));
        check("squash_ptr", 64'(bus.rr_ptr), 64'(3));

        // Load a full broadcast, then reset mid-cycle.
        do_cycle(8'b0011_1000, seq_pregs(), 1'b0, g);
        check("full_num", 64'(bus.num_cdb_valid), 64'(3));
        bus.squash       = 1'b0;
        bus.fu_req_valid = '1;
        #2;
        reset = 1'b0;
        #1;
        check("async_num", 64'(bus.num_cdb_valid), 64'(0));
        check("async_cdb", 64'(bus.cdb_preg), 64'(0));
        check("async_ptr", 64'(bus.rr_ptr), 64'(0));
        check("async_ready", 64'(bus.fu_req_ready), 64'(0));
        m_ptr = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Random traffic honouring the hold-until-granted contract.
        v = '0;
        p = seq_pregs();
        for (int c = 0; c < 300; c++) begin
            sq = ($urandom_range(0, 15) == 0);
            do_cycle(v, p, sq, g);
            if (sq) v = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!v[i] || g[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    p[i] = PHYS_REG_IDX'($urandom);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
